msrv32_bu_bp: RTL and testbench

// - Parametrised branch unit with a direct-mapped branch history table (BHT) of 2-bit counters.
// - Fetch stage: looks up a taken/not-taken prediction by PC.
// - Execute stage: resolves BRANCH/JAL/JALR exactly as the base branch unit, trains the BHT and flags mispredictions.
// - Sits between the PC mux and the fetch/execute pipeline registers.

---
 rtl/msrv32_bu_bp.sv | 166 ++++++++++++++++
 tb/tb_msrv32_bu_bp.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_bu_bp.sv
// msrv32_bu_bp: branch unit with a direct-mapped BHT of 2-bit saturating counters.
// Fetch side looks up a taken/not-taken prediction by PC; execute side resolves
// BRANCH/JAL/JALR, trains the BHT on conditional branches and flags mispredictions.
// Optional feature macro: MSRV32_BU_PERF_EN enables the branch/mispredict counters;
// when undefined, br_count_out/mp_count_out are tied to zero and no counter flops exist.
module msrv32_bu_bp #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic [XLEN-1:0] pc_f_in,
  output logic            predict_taken_out,
  input  logic            resolve_valid_in,
  input  logic            stall_in,
  input  logic [4:0]      opcode_6_to_2_in,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic [XLEN-1:0] pc_x_in,
  input  logic            pred_taken_x_in,
  output logic            branch_taken_out,
  output logic            mispredict_out,
  output logic            init_busy_out,
  output logic [31:0]     br_count_out,
  output logic [31:0]     mp_count_out
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  localparam logic [1:0] CTR_WEAK_NT = 2'b01;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] init_ptr;
  logic [1:0]       bht [BHT_DEPTH];

  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_x;
  logic             is_branch;
  logic             is_jal;
  logic             is_jalr;
  logic             is_ctrl;
  logic             cmp_taken;
  logic             fire;
  logic             train;
  logic             mp_next;
  logic [1:0]       ctr_x;
  logic [1:0]       ctr_next;

  // Word-aligned PC bits select the BHT entry on both sides.
  assign idx_f = pc_f_in[IDX_W+1:2];
  assign idx_x = pc_x_in[IDX_W+1:2];

  // PC bits outside the index field do not affect this unit.
  logic unused;
  assign unused = ^{pc_f_in[XLEN-1:IDX_W+2], pc_f_in[1:0],
                    pc_x_in[XLEN-1:IDX_W+2], pc_x_in[1:0]};

  assign is_branch = (opcode_6_to_2_in == OP_BRANCH);
  assign is_jal    = (opcode_6_to_2_in == OP_JAL);
  assign is_jalr   = (opcode_6_to_2_in == OP_JALR);
  assign is_ctrl   = is_branch | is_jal | is_jalr;

  // Conditional-branch comparator selected by funct3.
  always_comb begin
    cmp_taken = 1'b0;
    case (funct3_in)
      3'b000:  cmp_taken = (rs1_in == rs2_in);
      3'b001:  cmp_taken = (rs1_in != rs2_in);
      3'b100:  cmp_taken = ($signed(rs1_in) <  $signed(rs2_in));
      3'b101:  cmp_taken = ($signed(rs1_in) >= $signed(rs2_in));
      3'b110:  cmp_taken = (rs1_in <  rs2_in);
      3'b111:  cmp_taken = (rs1_in >= rs2_in);
      default: cmp_taken = 1'b0;
    endcase
  end

  assign branch_taken_out = is_jal | is_jalr | (is_branch & cmp_taken);

  // A resolve only counts while running, valid and not stalled.
  assign fire    = (state == RUN) & resolve_valid_in & ~stall_in;
  assign train   = fire & is_branch;
  assign mp_next = fire & is_ctrl & (branch_taken_out != pred_taken_x_in);

  // Prediction is forced low until every entry has been initialised.
  assign predict_taken_out = (state == RUN) & bht[idx_f][1];

  // Saturating update of the execute-side counter.
  always_comb begin
    ctr_x    = bht[idx_x];
    ctr_next = ctr_x;
    if (branch_taken_out) begin
      if (ctr_x != 2'b11) ctr_next = ctr_x + 2'b01;
    end else begin
      if (ctr_x != 2'b00) ctr_next = ctr_x - 2'b01;
    end
  end

  // Control FSM: INIT sweeps the table once, RUN holds until reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state          <= INIT;
      init_ptr       <= '0;
      init_busy_out  <= 1'b1;
      mispredict_out <= 1'b0;
    end else begin
      mispredict_out <= mp_next;
      case (state)
        INIT: begin
          if (init_ptr == IDX_W'(BHT_DEPTH - 1)) begin
            state         <= RUN;
            init_busy_out <= 1'b0;
          end else begin
            init_ptr <= init_ptr + IDX_W'(1);
          end
        end
        RUN: begin
          state         <= RUN;
          init_busy_out <= 1'b0;
        end
        default: begin
          state         <= INIT;
          init_ptr      <= '0;
          init_busy_out <= 1'b1;
        end
      endcase
    end
  end

  // BHT storage: init sweep writes weak-NT, otherwise conditional branches train.
  always_ff @(posedge clk_in) begin
    if (rst_n_in) begin
      if (state == INIT) begin
        bht[init_ptr] <= CTR_WEAK_NT;
      end else if (train) begin
        bht[idx_x] <= ctr_next;
      end
    end
  end

`ifdef MSRV32_BU_PERF_EN
  // Performance counters share the training/mispredict gating and wrap at 2^32.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      br_count_out <= '0;
      mp_count_out <= '0;
    end else begin
      if (fire & is_ctrl) br_count_out <= br_count_out + 32'd1;
      if (mp_next)        mp_count_out <= mp_count_out + 32'd1;
    end
  end
`else
  assign br_count_out = '0;
  assign mp_count_out = '0;
`endif

endmodule

// File: tb/tb_msrv32_bu_bp.sv
// Scoreboard bench for msrv32_bu_bp: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares the ones due in the current cycle.
module tb_msrv32_bu_bp;

  localparam int S_BUSY = 0;
  localparam int S_PRED = 1;
  localparam int S_TAKEN = 2;
  localparam int S_MISP = 3;
  localparam int S_BR = 4;
  localparam int S_MP = 5;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_IMM    = 5'b00100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        predict_taken;
  logic        resolve_valid;
  logic        stall;
  logic [4:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] pc_x;
  logic        pred_x;
  logic        branch_taken;
  logic        mispredict;
  logic        init_busy;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  msrv32_bu_bp #(.XLEN(32), .BHT_DEPTH(64)) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .pc_f_in          (pc_f),
    .predict_taken_out(predict_taken),
    .resolve_valid_in (resolve_valid),
    .stall_in         (stall),
    .opcode_6_to_2_in (opcode),
    .funct3_in        (funct3),
    .rs1_in           (rs1),
    .rs2_in           (rs2),
    .pc_x_in          (pc_x),
    .pred_taken_x_in  (pred_x),
    .branch_taken_out (branch_taken),
    .mispredict_out   (mispredict),
    .init_busy_out    (init_busy),
    .br_count_out     (br_count),
    .mp_count_out     (mp_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   br_m = 0;
  int   mp_m = 0;

  function automatic logic [31:0] dut_val(input int sel);
    case (sel)
      S_BUSY:  return {31'd0, init_busy};
      S_PRED:  return {31'd0, predict_taken};
      S_TAKEN: return {31'd0, branch_taken};
      S_MISP:  return {31'd0, mispredict};
      S_BR:    return br_count;
      default: return mp_count;
    endcase
  endfunction

  // Perf outputs read zero unless the counters are built in.
  function automatic logic [31:0] pe(input int v);
`ifdef MSRV32_BU_PERF_EN
    return 32'(v);
`else
    return 32'd0 + 32'(v - v);
`endif
  endfunction

  // Monitor: compare every expectation due this cycle, flag any that were missed.
  int mi;
  always @(negedge clk) begin
    logic [31:0] act;
    mi = 0;
    while (mi < sbq.size()) begin
      if (sbq[mi].cyc == cyc) begin
        act = dut_val(sbq[mi].sel);
        checks++;
        if (act !== sbq[mi].val) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %0h expected %0h", sbq[mi].name, cyc, act, sbq[mi].val);
        end
        sbq.delete(mi);
      end else if (sbq[mi].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cyc %0d never sampled (now %0d)", sbq[mi].name, sbq[mi].cyc, cyc);
        sbq.delete(mi);
      end else begin
        mi++;
      end
    end
  end

  task automatic expect_at(input int c, input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = c; e.sel = sel; e.val = v; e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic chk(input int sel, input logic [31:0] v, input string nm);
    expect_at(cyc, sel, v, nm);
  endtask

  task automatic chk_next(input int sel, input logic [31:0] v, input string nm);
    expect_at(cyc + 1, sel, v, nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pcx, input logic pred,
                       input logic v, input logic st);
    opcode = op; funct3 = f3; rs1 = a; rs2 = b; pc_x = pcx;
    pred_x = pred; resolve_valid = v; stall = st;
  endtask

  task automatic idle();
    drive(5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic perf_next(input string tag);
    chk_next(S_BR, pe(br_m), {tag, "_br_count"});
    chk_next(S_MP, pe(mp_m), {tag, "_mp_count"});
  endtask

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int w;
    rst_n = 1'b0;
    pc_f  = 32'h40;
    idle();
    repeat (3) step();
    chk(S_BUSY, 32'd1, "rst_busy");
    chk(S_MISP, 32'd0, "rst_misp");
    chk(S_PRED, 32'd0, "rst_pred");
    chk(S_BR, 32'd0, "rst_br_count");
    chk(S_MP, 32'd0, "rst_mp_count");

    // Release reset: busy for exactly 64 cycles, prediction forced low throughout.
    step();
    rst_n = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 64; k++) begin
      expect_at(c0 + k, S_BUSY, 32'd1, "init_busy_hi");
      expect_at(c0 + k, S_PRED, 32'd0, "init_pred_lo");
    end
    expect_at(c0 + 64, S_BUSY, 32'd0, "init_done");
    expect_at(c0 + 64, S_PRED, 32'd0, "post_init_pred");
    repeat (64) step();

    // BLT -1 < 1 signed: taken, predicted NT -> mispredict.
    step();
    drive(OP_BRANCH, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h80, 1'b0, 1'b1, 1'b0);
    chk(S_TAKEN, 32'd1, "blt_taken");
    chk_next(S_MISP, 32'd1, "blt_misp");
    br_m++; mp_m++;
    perf_next("blt");

    // BLTU 0xFFFFFFFF < 1 unsigned: not taken, matches prediction.
    step();
    drive(OP_BRANCH, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h80, 1'b0, 1'b1, 1'b0);
    chk(S_TAKEN, 32'd0, "bltu_taken");
    chk_next(S_MISP, 32'd0, "bltu_misp");
    br_m++;
    perf_next("bltu");

    // Three taken BEQ at 0x40: index 16 goes 01 -> 10 -> 11 -> 11.
    for (int k = 0; k < 3; k++) begin
      step();
      pc_f = 32'h40;
      drive(OP_BRANCH, 3'b000, 32'd5, 32'd5, 32'h40, 1'b1, 1'b1, 1'b0);
      chk(S_PRED, (k == 0) ? 32'd0 : 32'd1, "beq_train_pred");
      chk(S_TAKEN, 32'd1, "beq_taken");
      chk_next(S_MISP, 32'd0, "beq_misp");
      br_m++;
      perf_next("beq");
    end
    step();
    idle();
    pc_f = 32'h40;
    chk(S_PRED, 32'd1, "pred_0x40");
    step();
    pc_f = 32'h140;
    chk(S_PRED, 32'd1, "pred_alias_0x140");
    step();
    pc_f = 32'h44;
    chk(S_PRED, 32'd0, "pred_0x44_untouched");

    // JAL predicted taken: no mispredict, must not train index 32 (now 01).
    step();
    drive(OP_JAL, 3'b000, 32'd0, 32'd0, 32'h80, 1'b1, 1'b1, 1'b0);
    chk(S_TAKEN, 32'd1, "jal_taken");
    chk_next(S_MISP, 32'd0, "jal_misp");
    br_m++;
    perf_next("jal");

    // Stalled JAL with wrong prediction: no mispredict, counters frozen.
    step();
    drive(OP_JAL, 3'b000, 32'd0, 32'd0, 32'h80, 1'b0, 1'b1, 1'b1);
    chk(S_TAKEN, 32'd1, "jal_stall_taken");
    chk_next(S_MISP, 32'd0, "jal_stall_misp");
    perf_next("jal_stall");

    step();
    idle();
    pc_f = 32'h80;
    chk(S_PRED, 32'd0, "jal_no_train");

    // Non-control instruction with a mismatched prediction never flags.
    step();
    drive(OP_IMM, 3'b000, 32'd1, 32'd1, 32'h80, 1'b1, 1'b1, 1'b0);
    chk(S_TAKEN, 32'd0, "nonctrl_taken");
    chk_next(S_MISP, 32'd0, "nonctrl_misp");
    perf_next("nonctrl");

    // funct3 sweep with valid low: checks compare logic and valid gating.
    step(); drive(OP_BRANCH, 3'b001, 32'd3, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0);
    chk(S_TAKEN, 32'd0, "bne_eq_ops");
    step(); drive(OP_BRANCH, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 1'b0, 1'b0);
    chk(S_TAKEN, 32'd0, "bge_signed");
    step(); drive(OP_BRANCH, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 1'b0, 1'b0);
    chk(S_TAKEN, 32'd1, "bgeu");
    chk_next(S_MISP, 32'd0, "invalid_no_misp");
    perf_next("invalid");
    step(); drive(OP_BRANCH, 3'b010, 32'd3, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0);
    chk(S_TAKEN, 32'd0, "f3_010");
    step(); drive(OP_BRANCH, 3'b000, 32'd3, 32'd4, 32'h0, 1'b0, 1'b0, 1'b0);
    chk(S_TAKEN, 32'd0, "beq_ne_ops");
    step(); drive(OP_BRANCH, 3'b100, 32'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0);
    chk(S_TAKEN, 32'd0, "blt_pos_neg");
    step(); drive(OP_BRANCH, 3'b001, 32'd3, 32'd4, 32'h0, 1'b0, 1'b0, 1'b0);
    chk(S_TAKEN, 32'd1, "bne_ne_ops");

    // Same-cycle lookup and training on index 5: read-before-write.
    step();
    pc_f = 32'h14;
    drive(OP_BRANCH, 3'b000, 32'd7, 32'd7, 32'h14, 1'b0, 1'b1, 1'b0);
    chk(S_PRED, 32'd0, "rbw_same_cycle");
    chk_next(S_MISP, 32'd1, "rbw_misp");
    br_m++; mp_m++;
    perf_next("rbw");
    step();
    idle();
    chk(S_PRED, 32'd1, "rbw_next_cycle");

    // One-cycle reset in RUN with an in-flight mispredicting resolve.
    step();
    rst_n = 1'b0;
    pc_f = 32'h40;
    drive(OP_BRANCH, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 1'b1, 1'b0);
    chk_next(S_MISP, 32'd0, "rst_drop_misp");
    chk_next(S_BUSY, 32'd1, "rerst_busy");
    br_m = 0; mp_m = 0;
    perf_next("rerst");
    step();
    rst_n = 1'b1;
    idle();
    c0 = cyc;
    chk(S_PRED, 32'd0, "reinit_pred");
    expect_at(c0 + 63, S_BUSY, 32'd1, "reinit_busy_last");
    expect_at(c0 + 64, S_BUSY, 32'd0, "reinit_done");
    expect_at(c0 + 64, S_PRED, 32'd0, "reinit_counter_weak_nt");
    repeat (66) step();

    w = 0;
    while (sbq.size() != 0 && w < 100) begin
      step();
      w++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
